// File: rtl/ps2_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receiver_if
//  Description : Signal bundle between the PS/2 receiver and its environment
//                (the PS/2 device lines plus the interrupt scheduler's read
//                strobe and the receiver's FIFO status/data/error outputs).
//  Ports       : ps2i_clk, ps2i_data  - raw PS/2 lines from the device
//                ps2i_rdn             - active-low read strobe (scheduler)
//                ps2o_data_ready      - FIFO non-empty
//                ps2o_scan_code[7:0]  - FIFO head, 0 when empty
//                ps2o_err             - one-cycle error pulse
//                ps2o_overflow        - one-cycle dropped-byte pulse
//  Modports    : master - device/scheduler side (drives the ps2i_* lines)
//                slave  - receiver side (drives the ps2o_* lines)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_receiver_if;
    logic       ps2i_clk;
    logic       ps2i_data;
    logic       ps2i_rdn;
    logic       ps2o_data_ready;
    logic [7:0] ps2o_scan_code;
    logic       ps2o_err;
    logic       ps2o_overflow;

    modport master (
        output ps2i_clk,
        output ps2i_data,
        output ps2i_rdn,
        input  ps2o_data_ready,
        input  ps2o_scan_code,
        input  ps2o_err,
        input  ps2o_overflow
    );

    modport slave (
        input  ps2i_clk,
        input  ps2i_data,
        input  ps2i_rdn,
        output ps2o_data_ready,
        output ps2o_scan_code,
        output ps2o_err,
        output ps2o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_receiver
//  Description : PS/2 keyboard receiver. Synchronizes the raw PS/2 clock and
//                data lines, deserializes 11-bit frames (start, 8 data LSB
//                first, odd parity, stop) on PS/2 clock falling edges, and
//                buffers valid scan codes in a small circular FIFO that the
//                interrupt scheduler drains with an active-low read strobe.
//  Ports       : schi_clk  - system clock
//                schi_rst  - asynchronous active-low reset
//                bus       - ps2_receiver_if.slave (PS/2 lines, read strobe,
//                            data_ready / scan_code / err / overflow)
//  Parameters  : FIFO_DEPTH     - scan-code buffer entries (power of 2, >= 2)
//                TIMEOUT_CYCLES - schi_clk cycles allowed between PS/2 clock
//                                 falling edges inside a frame
//  Options     : PS2_BREAK_FILTER_EN - when defined, 0xF0 and the byte that
//                follows it are swallowed so only make codes are buffered
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic         schi_clk,
    input  wire logic         schi_rst,
    ps2_receiver_if.slave     bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Synchronizers and edge detector
    logic clk_s1_q,  clk_s1_d;
    logic clk_s2_q,  clk_s2_d;
    logic clk_prev_q, clk_prev_d;
    logic data_s1_q, data_s1_d;
    logic data_s2_q, data_s2_d;

    // Frame FSM
    state_t           state_q,  state_d;
    logic [7:0]       shreg_q,  shreg_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;
    logic             err_q,    err_d;
`ifdef PS2_BREAK_FILTER_EN
    logic             drop_next_q, drop_next_d;
`endif

    // FIFO
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic             rdn_prev_q, rdn_prev_d;
    logic             overflow_q, overflow_d;

    logic fe;
    logic pop;
    logic push_req;
    logic do_push;
    logic frame_ok;

    always_comb begin
        clk_s1_d   = bus.ps2i_clk;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        data_s1_d  = bus.ps2i_data;
        data_s2_d  = data_s1_q;
        rdn_prev_d = bus.ps2i_rdn;

        fe  = clk_prev_q && !clk_s2_q;
        // Pop on the first low sample of the read strobe, only if non-empty.
        pop = rdn_prev_q && !bus.ps2i_rdn && (count_q != '0);

        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        parity_d = parity_q;
        err_d    = 1'b0;
        push_req = 1'b0;
        frame_ok = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        drop_next_d = drop_next_q;
`endif

        // Watchdog restarts on every PS/2 clock edge and is idle between frames.
        tmo_d = (state_q == ST_IDLE || fe) ? '0 : tmo_q + TMO_W'(1);

        if (state_q != ST_IDLE && tmo_q == TMO_LIMIT) begin
            // Device stalled mid-frame: abandon the partial byte.
            state_d  = ST_IDLE;
            shreg_d  = '0;
            bitcnt_d = '0;
            tmo_d    = '0;
            err_d    = 1'b1;
        end else if (fe) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {data_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_s2_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d  = ST_IDLE;
                    frame_ok = data_s2_q && (^{shreg_q, parity_q});
                    if (frame_ok) begin
`ifdef PS2_BREAK_FILTER_EN
                        // Swallow the break prefix and the key code after it.
                        if (drop_next_q) begin
                            drop_next_d = 1'b0;
                        end else if (shreg_q == 8'hF0) begin
                            drop_next_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                        end
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // A pop in the same cycle frees the slot a full FIFO would lack.
        do_push    = push_req && ((count_q != FULL_COUNT) || pop);
        overflow_d = push_req && !do_push;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
    end

    always_ff @(posedge schi_clk or negedge schi_rst) begin
        if (!schi_rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            rdn_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef PS2_BREAK_FILTER_EN
            drop_next_q <= 1'b0;
`endif
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            clk_prev_q <= clk_prev_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            rdn_prev_q <= rdn_prev_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef PS2_BREAK_FILTER_EN
            drop_next_q <= drop_next_d;
`endif
        end
    end

    assign bus.ps2o_data_ready = (count_q != '0);
    assign bus.ps2o_scan_code  = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.ps2o_err        = err_q;
    assign bus.ps2o_overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_receiver
//  Description : Self-checking bench for ps2_receiver. Table of single-frame
//                vectors plus hand-written sequences for overflow, timeout,
//                simultaneous push/pop, break filtering and mid-frame reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic schi_clk = 1'b0;
    logic schi_rst = 1'b0;

    ps2_receiver_if bus ();

    ps2_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .schi_clk (schi_clk),
        .schi_rst (schi_rst),
        .bus      (bus)
    );

    always #5 schi_clk = ~schi_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int ovf_cnt  = 0;

    // Every high cycle is counted, so a stuck pulse shows up as extra counts.
    always @(negedge schi_clk) begin
        if (bus.ps2o_err      === 1'b1) err_cnt++;
        if (bus.ps2o_overflow === 1'b1) ovf_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge schi_clk);
    endtask

    task automatic send_bit(input logic b);
        bus.ps2i_data = b;
        tick(4);
        bus.ps2i_clk = 1'b0;
        tick(4);
        bus.ps2i_clk = 1'b1;
    endtask

    task automatic send_body(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ par_flip);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        send_body(d, par_flip);
        send_bit(stop);
        bus.ps2i_data = 1'b1;
        tick(6);
    endtask

    task automatic pop_strobe();
        bus.ps2i_rdn = 1'b0;
        tick(1);
        bus.ps2i_rdn = 1'b1;
        tick(1);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_ready"}, int'(bus.ps2o_data_ready), 1);
        check({name, "_code"},  int'(bus.ps2o_scan_code),  int'(exp));
        pop_strobe();
    endtask

    task automatic check_empty(input string name);
        check({name, "_ready"}, int'(bus.ps2o_data_ready), 0);
        check({name, "_code"},  int'(bus.ps2o_scan_code),  0);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       par_flip;
        logic       stop;
        logic       exp_push;
        int         exp_errs;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int e0;
        int o0;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 0};  // good frame
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1};  // parity error
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 0};  // all zeros, parity 1
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 0};  // all ones, parity 1
        vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1};  // framing error (stop 0)
        vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 0};  // MSB only

        bus.ps2i_clk  = 1'b1;
        bus.ps2i_data = 1'b1;
        bus.ps2i_rdn  = 1'b1;
        schi_rst      = 1'b0;
        tick(3);
        check("rst_ready",    int'(bus.ps2o_data_ready), 0);
        check("rst_code",     int'(bus.ps2o_scan_code),  0);
        check("rst_err",      int'(bus.ps2o_err),        0);
        check("rst_overflow", int'(bus.ps2o_overflow),   0);
        schi_rst = 1'b1;
        tick(3);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            e0 = err_cnt;
            send_frame(vecs[v].code, vecs[v].par_flip, vecs[v].stop);
            check($sformatf("vec%0d_err", v), err_cnt - e0, vecs[v].exp_errs);
            check($sformatf("vec%0d_ready", v), int'(bus.ps2o_data_ready), int'(vecs[v].exp_push));
            check($sformatf("vec%0d_code", v), int'(bus.ps2o_scan_code),
                  vecs[v].exp_push ? int'(vecs[v].code) : 0);
            if (vecs[v].exp_push) pop_strobe();
            check_empty($sformatf("vec%0d_after", v));
        end
        check("vec_no_overflow", ovf_cnt, 0);

        // Pop while empty is ignored
        pop_strobe();
        check_empty("empty_pop");

        // Falling PS/2 clock in idle with data high is a bad start bit
        e0 = err_cnt;
        send_bit(1'b1);
        tick(6);
        check("bad_start_err", err_cnt - e0, 1);
        check_empty("bad_start");

        // Overflow: fifth byte dropped, order of first four preserved
        o0 = ovf_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        check("ovf_before", ovf_cnt - o0, 0);
        send_frame(8'h55, 1'b0, 1'b1);
        check("ovf_pulse", ovf_cnt - o0, 1);
        pop_expect("ovf_pop0", 8'h11);
        pop_expect("ovf_pop1", 8'h22);
        pop_expect("ovf_pop2", 8'h33);
        pop_expect("ovf_pop3", 8'h44);
        check_empty("ovf_end");

        // Timeout mid-frame, then recovery
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        tick(TMO + 20);
        check("tmo_err", err_cnt - e0, 1);
        check_empty("tmo");
        send_frame(8'h1C, 1'b0, 1'b1);
        check("tmo_recover_err", err_cnt - e0, 1);
        pop_expect("tmo_recover", 8'h1C);
        check_empty("tmo_end");

        // Simultaneous push and pop with the FIFO full
        o0 = ovf_cnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b1);
        send_frame(8'h44, 1'b0, 1'b1);
        send_body(8'h55, 1'b0);
        bus.ps2i_data = 1'b1;
        tick(4);
        bus.ps2i_clk = 1'b0;       // stop-bit edge; fe seen two cycles later
        tick(2);
        bus.ps2i_rdn = 1'b0;       // first low sample coincides with that fe
        tick(1);
        bus.ps2i_rdn = 1'b1;
        tick(1);
        bus.ps2i_clk = 1'b1;
        tick(6);
        check("simul_no_ovf", ovf_cnt - o0, 0);
        pop_expect("simul_pop0", 8'h22);
        pop_expect("simul_pop1", 8'h33);
        pop_expect("simul_pop2", 8'h44);
        pop_expect("simul_pop3", 8'h55);
        check_empty("simul_end");

        // Break-code stream
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        pop_expect("brk_pop0", 8'h1C);
`else
        pop_expect("brk_pop0", 8'h1C);
        pop_expect("brk_pop1", 8'hF0);
        pop_expect("brk_pop2", 8'h1C);
`endif
        check_empty("brk_end");

        // Reset mid-frame empties the FIFO and drops the partial byte
        send_frame(8'h11, 1'b0, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        schi_rst = 1'b0;
        tick(2);
        check_empty("midrst");
        schi_rst = 1'b1;
        tick(2);
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("midrst_err", err_cnt - e0, 0);
        pop_expect("midrst_pop", 8'h1C);
        check_empty("midrst_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
